// File: rtl/cpu_pkg.sv
// Shared CPU types: default datapath sizes and the write-back request record.
package cpu_pkg;

    localparam int unsigned DefaultWidth = 8;
    localparam int unsigned DefaultDepth = 4;
    localparam int unsigned DefaultAw    = $clog2(DefaultDepth);

    typedef logic [DefaultAw-1:0]    reg_addr_t;
    typedef logic [DefaultWidth-1:0] word_t;

    typedef struct packed {
        reg_addr_t addr;
        word_t     data;
    } wb_req_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Write-back bus bundle: two result sources, issue reservation, register-file write port.
interface wb_arbiter_if
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned DEPTH = DefaultDepth
) ();
    localparam int unsigned AW = $clog2(DEPTH);

    logic             alu_valid;
    logic             alu_ready;
    logic [AW-1:0]    alu_addr;
    logic [WIDTH-1:0] alu_data;
    logic             lsu_valid;
    logic             lsu_ready;
    logic [AW-1:0]    lsu_addr;
    logic [WIDTH-1:0] lsu_data;
    logic             issue_valid;
    logic [AW-1:0]    issue_addr;
    logic [DEPTH-1:0] busy;
    logic             rf_we;
    logic [AW-1:0]    rf_waddr;
    logic [WIDTH-1:0] rf_wdata;
    logic             err_waw;
    logic             err_spurious;

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  lsu_valid, lsu_addr, lsu_data,
        input  issue_valid, issue_addr,
        output alu_ready, lsu_ready, busy,
        output rf_we, rf_waddr, rf_wdata,
        output err_waw, err_spurious
    );

    modport master (
        output alu_valid, alu_addr, alu_data,
        output lsu_valid, lsu_addr, lsu_data,
        output issue_valid, issue_addr,
        input  alu_ready, lsu_ready, busy,
        input  rf_we, rf_waddr, rf_wdata,
        input  err_waw, err_spurious
    );

endinterface

// File: rtl/wb_slot.sv
// One-entry holding register for a result source; ready is purely registered.
module wb_slot
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned AW    = DefaultAw
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             drain_i,
    output logic             full_o,
    output logic [AW-1:0]    addr_o,
    output logic [WIDTH-1:0] data_o
);

    logic             full_q, full_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [WIDTH-1:0] data_q, data_d;

    // A draining slot is still full, so it cannot also accept this cycle.
    always_comb begin
        full_d = full_q;
        addr_d = addr_q;
        data_d = data_q;
        if (drain_i) begin
            full_d = 1'b0;
        end else if (valid_i && !full_q) begin
            full_d = 1'b1;
            addr_d = addr_i;
            data_d = data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign ready_o = !full_q;
    assign full_o  = full_q;
    assign addr_o  = addr_q;
    assign data_o  = data_q;

endmodule

// File: rtl/wb_arbiter.sv
// Write-back stage: round-robin merge of ALU and LSU slots onto the register-file
// write port, plus the per-register busy scoreboard and sticky protocol-error flags.
module wb_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned DEPTH = DefaultDepth
) (
    input logic         clk,
    input logic         rst,
    wb_arbiter_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic             alu_full, lsu_full;
    logic [AW-1:0]    alu_saddr, lsu_saddr;
    logic [WIDTH-1:0] alu_sdata, lsu_sdata;
    logic             grant_alu, grant_lsu;

    logic             rf_we;
    logic [AW-1:0]    rf_waddr;
    logic [WIDTH-1:0] rf_wdata;

    logic             rr_ptr_q, rr_ptr_d;
    logic [DEPTH-1:0] busy_q, busy_d;
    logic             err_waw_q, err_waw_d;
    logic             err_spurious_q, err_spurious_d;
    logic             clearing_issue;

    wb_slot #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_alu_slot (
        .clk     (clk),
        .rst     (rst),
        .valid_i (bus.alu_valid),
        .ready_o (bus.alu_ready),
        .addr_i  (bus.alu_addr),
        .data_i  (bus.alu_data),
        .drain_i (grant_alu),
        .full_o  (alu_full),
        .addr_o  (alu_saddr),
        .data_o  (alu_sdata)
    );

    wb_slot #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_lsu_slot (
        .clk     (clk),
        .rst     (rst),
        .valid_i (bus.lsu_valid),
        .ready_o (bus.lsu_ready),
        .addr_i  (bus.lsu_addr),
        .data_i  (bus.lsu_data),
        .drain_i (grant_lsu),
        .full_o  (lsu_full),
        .addr_o  (lsu_saddr),
        .data_o  (lsu_sdata)
    );

    // rr_ptr=0 prefers ALU when both slots hold a result.
    assign grant_alu = alu_full && (!lsu_full || !rr_ptr_q);
    assign grant_lsu = lsu_full && !grant_alu;

    always_comb begin
        rf_we    = alu_full || lsu_full;
        rf_waddr = '0;
        rf_wdata = '0;
        rr_ptr_d = rr_ptr_q;
        if (grant_alu) begin
            rf_waddr = alu_saddr;
            rf_wdata = alu_sdata;
            rr_ptr_d = 1'b1;
        end else if (grant_lsu) begin
            rf_waddr = lsu_saddr;
            rf_wdata = lsu_sdata;
            rr_ptr_d = 1'b0;
        end
    end

    assign clearing_issue = rf_we && (rf_waddr == bus.issue_addr);

    // Clear before set so a same-cycle reservation of a retiring register survives.
    always_comb begin
        busy_d = busy_q;
        if (rf_we) busy_d[rf_waddr] = 1'b0;
        if (bus.issue_valid) busy_d[bus.issue_addr] = 1'b1;
        err_waw_d = err_waw_q ||
                    (bus.issue_valid && busy_q[bus.issue_addr] && !clearing_issue);
        err_spurious_d = err_spurious_q || (rf_we && !busy_q[rf_waddr]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q       <= 1'b0;
            busy_q         <= '0;
            err_waw_q      <= 1'b0;
            err_spurious_q <= 1'b0;
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            busy_q         <= busy_d;
            err_waw_q      <= err_waw_d;
            err_spurious_q <= err_spurious_d;
        end
    end

    assign bus.rf_we        = rf_we;
    assign bus.rf_waddr     = rf_waddr;
    assign bus.rf_wdata     = rf_wdata;
    assign bus.busy         = busy_q;
    assign bus.err_waw      = err_waw_q;
    assign bus.err_spurious = err_spurious_q;

endmodule
